// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arbiter_pkg;

  localparam int DEFAULT_AW      = 16;
  localparam int DEFAULT_DW      = 16;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin pick: on a tie the requester that did not
// win last time is chosen.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  assign valid = req0 | req1;
  assign grant = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between two masters, one transaction at a time,
// round-robin, with a per-transaction ready timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = DEFAULT_AW,
  parameter int DW      = DEFAULT_DW,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          err0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata1,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          timeout_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_reg;
  logic          last_grant_reg;
  logic          grant_reg;
  logic          timed_out_reg;
  logic [CW-1:0] cnt_reg;
  logic          ack0_reg, ack1_reg, err0_reg, err1_reg;
  logic [DW-1:0] rdata0_reg, rdata1_reg;
  logic          mem_req_reg, mem_we_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_wdata_reg;
  logic          timeout_err_reg;

  logic arb_grant;
  logic arb_valid;

  rr_arb2 u_rr_arb2 (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_reg),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      last_grant_reg  <= 1'b1;
      grant_reg       <= 1'b0;
      timed_out_reg   <= 1'b0;
      cnt_reg         <= '0;
      ack0_reg        <= 1'b0;
      ack1_reg        <= 1'b0;
      err0_reg        <= 1'b0;
      err1_reg        <= 1'b0;
      rdata0_reg      <= '0;
      rdata1_reg      <= '0;
      mem_req_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      // Completion strobes are single-cycle pulses by default.
      ack0_reg <= 1'b0;
      ack1_reg <= 1'b0;
      err0_reg <= 1'b0;
      err1_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_reg      <= arb_grant;
            last_grant_reg <= arb_grant;
            mem_req_reg    <= 1'b1;
            mem_we_reg     <= arb_grant ? we1 : we0;
            mem_addr_reg   <= arb_grant ? addr1 : addr0;
            mem_wdata_reg  <= arb_grant ? wdata1 : wdata0;
            cnt_reg        <= '0;
            timed_out_reg  <= 1'b0;
            state_reg      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            if (!mem_we_reg) begin
              if (grant_reg) rdata1_reg <= mem_rdata;
              else           rdata0_reg <= mem_rdata;
            end
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            state_reg   <= ST_DONE;
          end else if (cnt_reg == CNT_LAST) begin
            mem_req_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;
            timed_out_reg   <= 1'b1;
            timeout_err_reg <= 1'b1;
            state_reg       <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_DONE: begin
          if (grant_reg) begin
            ack1_reg <= 1'b1;
            err1_reg <= timed_out_reg;
          end else begin
            ack0_reg <= 1'b1;
            err0_reg <= timed_out_reg;
          end
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ack0        = ack0_reg;
  assign ack1        = ack1_reg;
  assign err0        = err0_reg;
  assign err1        = err1_reg;
  assign rdata0      = rdata0_reg;
  assign rdata1      = rdata1_reg;
  assign mem_req     = mem_req_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign timeout_err = timeout_err_reg;
  assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs change and outputs are
// sampled on the falling edge.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, err0, ack1, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_req, mem_we, mem_ready, busy, timeout_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic apply_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({busy, mem_req, mem_we, ack0, ack1, err0, err1, timeout_err} !== 8'h00) begin
      failures++; $display("FAIL reset_flags: got %b expected 00000000", {busy, mem_req, mem_we, ack0, ack1, err0, err1, timeout_err}); end
    checks++; if (rdata0 !== 16'h0000) begin failures++; $display("FAIL reset_rdata0: got %h expected 0000", rdata0); end
    checks++; if (rdata1 !== 16'h0000) begin failures++; $display("FAIL reset_rdata1: got %h expected 0000", rdata1); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    checks++; if (mem_wdata !== 16'h0000) begin failures++; $display("FAIL reset_mem_wdata: got %h expected 0000", mem_wdata); end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010; mem_rdata = 16'hBEEF; mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rd_grant: got mem_req=%b busy=%b expected 1 1", mem_req, busy); end
    checks++; if (mem_addr !== 16'h0010) begin failures++; $display("FAIL rd_addr: got %h expected 0010", mem_addr); end
    checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL rd_early_ack1: got %b expected 0", ack0); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || ack0 !== 1'b0) begin failures++; $display("FAIL rd_done: got mem_req=%b ack0=%b expected 0 0", mem_req, ack0); end
    @(negedge clk);
    checks++; if (ack0 !== 1'b1 || err0 !== 1'b0 || ack1 !== 1'b0) begin failures++; $display("FAIL rd_ack: got ack0=%b err0=%b ack1=%b expected 1 0 0", ack0, err0, ack1); end
    checks++; if (rdata0 !== 16'hBEEF) begin failures++; $display("FAIL rd_rdata0: got %h expected beef", rdata0); end
    req0 = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rd_ack_pulse: got ack0=%b busy=%b expected 0 0", ack0, busy); end
    $display("test_single_read done");
  endtask

  task automatic test_write_wait();
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'h1234; mem_rdata = 16'hDEAD; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we} !== 2'b11 || mem_wdata !== 16'h1234 || mem_addr !== 16'h0020) begin
        failures++; $display("FAIL wr_hold%0d: got req/we=%b wdata=%h addr=%h expected 11 1234 0020", i, {mem_req, mem_we}, mem_wdata, mem_addr); end
      if (i == 3) mem_ready = 1'b1;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if ({mem_req, mem_we, ack1} !== 3'b000) begin failures++; $display("FAIL wr_done: got req/we/ack1=%b expected 000", {mem_req, mem_we, ack1}); end
    @(negedge clk);
    checks++; if (ack1 !== 1'b1 || err1 !== 1'b0 || ack0 !== 1'b0) begin failures++; $display("FAIL wr_ack: got ack1=%b err1=%b ack0=%b expected 1 0 0", ack1, err1, ack0); end
    checks++; if (rdata1 !== 16'h0000) begin failures++; $display("FAIL wr_rdata1: got %h expected 0000", rdata1); end
    req1 = 1'b0; we1 = 1'b0;
    @(negedge clk);
    $display("test_write_wait done");
  endtask

  task automatic test_fairness();
    logic exp_grant;
    int   n;
    apply_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0100; addr1 = 16'h0200; mem_ready = 1'b1; mem_rdata = 16'h0055;
    exp_grant = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk);
      checks++; if (ack0 && ack1) begin failures++; $display("FAIL rr_overlap: got ack0=%b ack1=%b expected not both", ack0, ack1); end
      if (ack0 || ack1) begin
        checks++; if (ack1 !== exp_grant) begin failures++; $display("FAIL rr_order%0d: got requester %0d expected %0d", n, ack1, exp_grant); end
        $display("rr transaction %0d acked requester %0d", n, ack1);
        exp_grant = ~exp_grant;
        n++;
        if (n == 6) begin req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0; end
      end
    end
    checks++; if (n != 6) begin failures++; $display("FAIL rr_count: got %0d acks expected 6", n); end
    @(negedge clk);
    $display("test_fairness done");
  endtask

  task automatic test_timeout();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0030; mem_ready = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b1 || ack0 !== 1'b0) begin failures++; $display("FAIL to_wait%0d: got mem_req=%b ack0=%b expected 1 0", k, mem_req, ack0); end
    end
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || timeout_err !== 1'b1 || ack0 !== 1'b0) begin
      failures++; $display("FAIL to_abort: got mem_req=%b timeout_err=%b ack0=%b expected 0 1 0", mem_req, timeout_err, ack0); end
    @(negedge clk);
    checks++; if (ack0 !== 1'b1 || err0 !== 1'b1) begin failures++; $display("FAIL to_ack: got ack0=%b err0=%b expected 1 1", ack0, err0); end
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (timeout_err !== 1'b1 || err0 !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL to_sticky: got timeout_err=%b err0=%b busy=%b expected 1 0 0", timeout_err, err0, busy); end
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid_access();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
    rst_n = 1'b0; req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({busy, mem_req, ack0, ack1, timeout_err} !== 5'b00000) begin
      failures++; $display("FAIL rst_abort: got busy/req/ack0/ack1/to=%b expected 00000", {busy, mem_req, ack0, ack1, timeout_err}); end
    @(negedge clk);
    checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin failures++; $display("FAIL rst_no_ack: got ack0=%b ack1=%b expected 0 0", ack0, ack1); end
    req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr0 = 16'h0040; addr1 = 16'h0050;
    mem_ready = 1'b1; mem_rdata = 16'h5A5A;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040) begin failures++; $display("FAIL rst_first_grant: got mem_req=%b addr=%h expected 1 0040", mem_req, mem_addr); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (ack0 !== 1'b1 || rdata0 !== 16'h5A5A) begin failures++; $display("FAIL rst_ack0: got ack0=%b rdata0=%h expected 1 5a5a", ack0, rdata0); end
    req0 = 1'b0; mem_rdata = 16'h6B6B;
    repeat (3) @(negedge clk);
    checks++; if (ack1 !== 1'b1 || rdata1 !== 16'h6B6B) begin failures++; $display("FAIL rst_ack1: got ack1=%b rdata1=%h expected 1 6b6b", ack1, rdata1); end
    req1 = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    $display("test_reset_mid_access done");
  endtask

  task automatic test_spurious_ready();
    mem_ready = 1'b1; mem_rdata = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({busy, mem_req, ack0, ack1} !== 4'b0000) begin failures++; $display("FAIL spur_state%0d: got busy/req/ack0/ack1=%b expected 0000", i, {busy, mem_req, ack0, ack1}); end
      checks++; if (rdata0 !== 16'h5A5A || rdata1 !== 16'h6B6B) begin failures++; $display("FAIL spur_rdata%0d: got %h %h expected 5a5a 6b6b", i, rdata0, rdata1); end
    end
    mem_ready = 1'b0;
    $display("test_spurious_ready done");
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_single_read();
    test_write_wait();
    test_fairness();
    test_timeout();
    test_reset_mid_access();
    test_spurious_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single `memory` block between the CPU (requester 0) and a secondary master such as a program loader or debug port (requester 1).
- Sits between both masters and `memory` in `top`. It drives memory's write strobe, address and write data, and consumes `memory_ready` and read data.
- Arbitration is round-robin, one transaction at a time, with a per-transaction timeout that reports a stuck memory.

Parameters:
- AW, 16, address width
- DW, 16, data width
- TIMEOUT, 255, max cycles waiting for mem_ready before abort (≥1)

Ports:
- clk  in  1  system clock (cpu_clk domain)
- rst_n  in  1  synchronous active-low reset
- req0  in  1  CPU request, held until ack0
- we0  in  1  CPU write enable (1=write)
- addr0  in  AW  CPU address
- wdata0  in  DW  CPU write data
- ack0  out  1  one-cycle completion pulse to CPU
- err0  out  1  qualifies ack0: transaction timed out
- rdata0  out  DW  read data to CPU, valid with ack0, held until next ack0
- req1, we1, addr1, wdata1, ack1, err1, rdata1: same as above for requester 1
- mem_req  out  1  transaction active toward memory
- mem_we  out  1  write strobe to memory
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- mem_ready  in  1  memory done, single-cycle or level
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky, set on any timeout, cleared only by reset

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all ack/err/mem_req/mem_we/busy/timeout_err=0; rdata0/1, mem_addr, mem_wdata=0; last_grant=1, so requester 0 wins the first tie; timeout counter=0. Reset mid-transaction aborts silently, with no ack.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req, grant it.
  - If both req, grant the requester != last_grant.
  - On grant: latch addr/we/wdata into mem_addr/mem_we/mem_wdata, set mem_req=1, record grant, update last_grant, clear counter, go to ACCESS.
- ACCESS:
  - mem outputs held stable.
  - On mem_ready=1: capture mem_rdata into the granted rdata register (reads only; writes leave rdata unchanged). Drop mem_req and mem_we, go to DONE.
  - Otherwise increment the counter. When counter==TIMEOUT-1 with no mem_ready: drop mem_req and mem_we, set err flag and timeout_err, go to DONE.
- DONE: assert ack of the granted requester for exactly one cycle, with err asserted if timed out. Requests are ignored in DONE. Next state is IDLE.
- Latency:
  - req sampled in IDLE at edge N gives mem_req=1 after edge N.
  - mem_ready sampled at edge M gives ack=1 after edge M+1.
  - Zero-wait memory, with mem_ready in the first ACCESS cycle, gives 3 cycles from req to ack.
- Requester rules:
  - Keep req/addr/we/wdata stable until ack.
  - Drop req in the ack cycle, or keep it high to issue a back-to-back transaction, which is re-arbitrated in IDLE.
- Fairness: with both requesting continuously, grants strictly alternate 0,1,0,1.
- mem_ready asserted while in IDLE or DONE is ignored.
- ack0 and ack1 are never high together.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2) and default widths.
- One natural sub-module, `rr_arb2`: combinational 2-way round-robin pick from req0/req1/last_grant, producing a grant index and a valid flag.
- FSM, latches and timeout counter stay in mem_arbiter.

Test Plan:
- Single CPU read, memory ready on first ACCESS cycle:
  - Stimulus: req0=1, we0=0, addr0=16'h0010; mem_rdata=16'hBEEF.
  - Response: mem_req high for 1 cycle with mem_addr=16'h0010; ack0 pulses 3 cycles after req; rdata0=16'hBEEF; err0=0.
- Write from requester 1 with memory ready after 4 cycles:
  - Stimulus: req1=1, we1=1, addr1=16'h0020, wdata1=16'h1234.
  - Response: mem_we=1, mem_wdata=16'h1234 stable for all 4 ACCESS cycles; ack1 one cycle after ready; rdata1 unchanged.
- Both request continuously from reset for 6 transactions:
  - Response: grant order 0,1,0,1,0,1; ack0 and ack1 never overlap.
- Timeout with TIMEOUT=8 and mem_ready held 0:
  - Response: mem_req drops after 8 ACCESS cycles; ack0=1 with err0=1; timeout_err stays 1 until reset.
- Reset during ACCESS:
  - Stimulus: rst_n=0 for 1 cycle mid-wait.
  - Response: next cycle busy=0, mem_req=0, no ack; a subsequent request from both masters grants requester 0 first.
- Spurious mem_ready:
  - Stimulus: mem_ready=1 while in IDLE with no req.
  - Response: no state change, no ack, rdata registers unchanged.
